// File: rtl/xbar_select_loader.sv
// Purpose : serial loader for the crossbar select map; shadow bank committed atomically to select_o.
// Latency : last beat accepted at edge N, new select_o and 1-cycle commit_o visible after edge N+1.
// Backpr. : cfg_ready_o drops only during the single COMMIT cycle; abort_i drops the same-cycle beat.
//
// Ports:
//   clk_i, arst_ni           clock, asynchronous active-low reset
//   cfg_data_i/_valid_i      select value stream in, cfg_ready_o handshake out
//   abort_i                  discard the frame in progress (ignored during COMMIT)
//   select_o[NUM_ELEM]       active map, drives crossbar select inputs directly
//   commit_o                 pulse on the first cycle select_o shows a new map
//   busy_o                   frame in progress
//   error_o                  sticky out-of-range flag for the current/last frame
module xbar_select_loader #(
    parameter  int NUM_ELEM = 5,
    localparam int SEL_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [SEL_W-1:0] cfg_data_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic             abort_i,
    output logic [SEL_W-1:0] select_o [NUM_ELEM],
    output logic             commit_o,
    output logic             busy_o,
    output logic             error_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_ELEM - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_slot;
    logic [SEL_W-1:0] r_shadow [NUM_ELEM];
    logic [SEL_W-1:0] r_select [NUM_ELEM];
    logic             r_commit;
    logic             r_error;

    logic             w_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_abort;
    logic             w_illegal;
    logic             w_last;
    logic [SEL_W-1:0] w_wdat;

    assign w_accept  = cfg_valid_i && w_ready && !abort_i;
    // Abort only has an effect outside COMMIT; a commit always completes.
    assign w_abort   = abort_i && (r_state != ST_COMMIT);
    assign w_illegal = ({1'b0, cfg_data_i} >= (SEL_W + 1)'(NUM_ELEM));
    assign w_last    = (r_slot == LAST_SLOT);
    // Illegal selects are replaced by the slot's own index so that port passes straight through.
    assign w_wdat    = w_illegal ? r_slot : cfg_data_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (NUM_ELEM == 1) ? ST_COMMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && w_last) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        case (r_state)
            ST_IDLE:   w_busy  = 1'b0;
            ST_COMMIT: w_ready = 1'b0;
            default: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_slot   <= '0;
            r_commit <= 1'b0;
            r_error  <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_shadow[i] <= SEL_W'(i);
                r_select[i] <= SEL_W'(i);
            end
        end else begin
            r_commit <= (r_state == ST_COMMIT);
            if (r_state == ST_COMMIT) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    r_select[i] <= r_shadow[i];
                end
            end
            if (w_abort) begin
                r_slot <= '0;
            end else if (w_accept) begin
                r_shadow[r_slot] <= w_wdat;
                r_slot           <= w_last ? '0 : r_slot + SEL_W'(1);
                // First beat of a frame restarts the sticky flag.
                r_error          <= (r_state == ST_IDLE) ? w_illegal : (r_error | w_illegal);
            end
        end
    end

    assign cfg_ready_o = w_ready;
    assign busy_o      = w_busy;
    assign commit_o    = r_commit;
    assign error_o     = r_error;
    assign select_o    = r_select;

endmodule

// File: tb/tb_xbar_select_loader.sv
module tb_xbar_select_loader;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       arst_ni;
    logic [2:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       abort;
    logic [2:0] sel [N];
    logic       commit;
    logic       busy;
    logic       error;

    always #5 clk = ~clk;

    xbar_select_loader #(.NUM_ELEM(N)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .cfg_data_i  (cfg_data),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .abort_i     (abort),
        .select_o    (sel),
        .commit_o    (commit),
        .busy_o      (busy),
        .error_o     (error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Downstream crossbar stand-in: out[i] = in_dat[select[i]]
    logic [3:0] in_dat [N];
    function automatic logic [3:0] xb_out(input int i);
        return in_dat[sel[i]];
    endfunction

    // ---------------- reference model (frame-level) ----------------
    int m_beats [$];   // sanitised beats of the frame being collected
    int m_map   [N];   // completed frame waiting for its commit cycle
    bit m_pending;     // a completed frame commits on the next edge
    int m_sel   [N];
    bit m_commit;
    bit m_err;
    int m_commits;

    function automatic void model_reset();
        m_beats.delete();
        m_pending = 0;
        m_commit  = 0;
        m_err     = 0;
        for (int i = 0; i < N; i++) m_sel[i] = i;
    endfunction

    // Effect of one rising edge given the inputs held before it.
    function automatic void model_edge(input bit v, input int d, input bit ab);
        int val;
        m_commit = 0;
        if (m_pending) begin
            m_sel     = m_map;
            m_commit  = 1;
            m_pending = 0;
            m_commits++;
        end else if (ab) begin
            m_beats.delete();
        end else if (v) begin
            val = (d >= N) ? m_beats.size() : d;
            if (m_beats.size() == 0) m_err = (d >= N);
            else                     m_err = m_err | (d >= N);
            m_beats.push_back(val);
            if (m_beats.size() == N) begin
                for (int i = 0; i < N; i++) m_map[i] = m_beats[i];
                m_beats.delete();
                m_pending = 1;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < N; i++) check({tag, ".sel"}, 32'(sel[i]), 32'(m_sel[i]));
        check({tag, ".commit"}, 32'(commit), 32'(m_commit));
        check({tag, ".busy"},   32'(busy),   32'(m_beats.size() != 0 || m_pending));
        check({tag, ".ready"},  32'(cfg_ready), 32'(!m_pending));
        check({tag, ".error"},  32'(error),  32'(m_err));
    endtask

    // Called at posedge+1; drives inputs, advances one edge, checks at posedge+1.
    task automatic cycle(input bit v, input int d, input bit ab, input string tag);
        cfg_valid = v;
        cfg_data  = 3'(d);
        abort     = ab;
        model_edge(v, d, ab);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_frame(input int f [N], input string tag);
        for (int i = 0; i < N; i++) cycle(1'b1, f[i], 1'b0, tag);
    endtask

    int f_rev [N] = '{4, 3, 2, 1, 0};
    int f_bad [N] = '{0, 7, 2, 5, 1};
    int f_one [N] = '{1, 1, 1, 1, 1};
    int f_mix [N] = '{2, 0, 4, 1, 3};

    initial begin
        for (int i = 0; i < N; i++) in_dat[i] = 4'(i * 3 + 1);
        arst_ni   = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        abort     = 1'b0;
        m_commits = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 arst_ni = 1'b1;
        #1 check_outputs("reset");
        @(posedge clk); #1;

        // Reversal frame, back-to-back beats; commit exactly 6 cycles after beat 0 is presented
        send_frame(f_rev, "rev");
        check("rev.no_commit_c5", 32'(commit), 32'd0);
        cycle(1'b0, 0, 1'b0, "rev_commit");
        check("rev.latency6", 32'(commit), 32'd1);
        for (int i = 0; i < N; i++) check("rev.xbar", 32'(xb_out(i)), 32'(in_dat[N-1-i]));
        cycle(1'b0, 0, 1'b0, "rev_idle");

        // Out-of-range values are sanitised and flagged
        send_frame(f_bad, "bad");
        cycle(1'b0, 0, 1'b0, "bad_commit");
        check("bad.sel4", 32'(sel[4]), 32'd1);
        check("bad.sel1", 32'(sel[1]), 32'd1);
        check("bad.error", 32'(error), 32'd1);

        // Next frame's first beat clears error; abort after 3 beats drops the 4th
        cycle(1'b1, 2, 1'b0, "ab_b0");
        check("clr.error", 32'(error), 32'd0);
        cycle(1'b1, 3, 1'b0, "ab_b1");
        cycle(1'b1, 4, 1'b0, "ab_b2");
        cycle(1'b1, 0, 1'b1, "ab_abort");
        check("ab.busy", 32'(busy), 32'd0);
        repeat (3) cycle(1'b0, 0, 1'b0, "ab_quiet");
        send_frame(f_one, "one");
        cycle(1'b0, 0, 1'b0, "one_commit");
        for (int i = 0; i < N; i++) check("one.xbar", 32'(xb_out(i)), 32'(in_dat[1]));

        // Random frames with ~50% valid and rare aborts
        begin
            int guard = 0;
            int target = m_commits + 100;
            while (m_commits < target && guard < 20000) begin
                cycle(1'(($urandom % 2)), int'($urandom_range(0, 7)), ($urandom % 40) == 0, "rand");
                guard++;
            end
            check("rand.commits_done", 32'(m_commits), 32'(target));
        end

        // Reset in the middle of a frame
        cycle(1'b1, 4, 1'b0, "rm_b0");
        cycle(1'b1, 4, 1'b0, "rm_b1");
        cfg_valid = 1'b0;
        arst_ni   = 1'b0;
        model_reset();
        #1 check_outputs("rst_mid");
        @(posedge clk); #1;
        arst_ni = 1'b1;
        #1;
        send_frame(f_mix, "after_rst");
        cycle(1'b0, 0, 1'b0, "after_rst_commit");
        check("after_rst.commit", 32'(commit), 32'd1);
        check("after_rst.sel2", 32'(sel[2]), 32'd4);
        cycle(1'b0, 0, 1'b0, "after_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
